// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants for the two-port SRAM arbiter: FSM state encoding and
//   default bus widths. Imported by mem_arbiter.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN (see arb_rr_pick).
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W_DEF  = 32;  // ADDRESS_LEN
   localparam int ARB_WDATA_W_DEF = 32;  // SRAM_DATA_LEN
   localparam int ARB_RDATA_W_DEF = 64;  // CACHE_BLOCK_DATA_LEN

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// arb_rr_pick
//   Combinational 2-way request picker.
//   Ports:
//     req[1:0]  in   per-port request (rd_en | wr_en)
//     last_gnt  in   port that completed the previous transaction
//     valid     out  at least one request present
//     pick      out  chosen port
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   defined   -> port 0 wins simultaneous requests
//   undefined -> round-robin, simultaneous requests go to !last_gnt
//   A lone request is always picked regardless of mode.
module arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       valid,
   output logic       pick
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   // last_gnt has no influence on the fixed-priority choice.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

   always_comb begin
      valid = |req;
      pick  = 1'b0;
      if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         pick = 1'b0;
`else
         pick = ~last_gnt;
`endif
      end else begin
         // Single (or no) request: port 1 only if it is the one asking.
         pick = req[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one SRAM controller port between the data-cache controller
//   (port 0) and instruction fetch (port 1). One requester is granted at a
//   time; the SRAM enables are held until sram_ready, then the granted port
//   sees a one-cycle ready in the DONE state.
//   Ports:
//     clk, rst                 clock (rising) / async active-low reset
//     rN_rd_en, rN_wr_en       N=0,1 request enables, held until rN_ready
//     rN_address, rN_write_data N=0,1 request address / write data
//     rN_ready                 N=0,1 low = stall requester
//     rN_read_data             N=0,1 last block read for that port
//     sram_ready               done pulse from SRAM controller
//     sram_read_data           block read data from SRAM controller
//     sram_rd_en, sram_wr_en   enables to SRAM controller
//     sram_address, sram_write_data  muxed from granted port
// Configuration macro: MEM_ARB_FIXED_PRIO_EN (fixed priority, port 0 wins).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W_DEF,
   parameter int WDATA_W = ARB_WDATA_W_DEF,
   parameter int RDATA_W = ARB_RDATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               r0_rd_en,
   input  logic               r0_wr_en,
   input  logic [ADDR_W-1:0]  r0_address,
   input  logic [WDATA_W-1:0] r0_write_data,
   output logic               r0_ready,
   output logic [RDATA_W-1:0] r0_read_data,
   input  logic               r1_rd_en,
   input  logic               r1_wr_en,
   input  logic [ADDR_W-1:0]  r1_address,
   input  logic [WDATA_W-1:0] r1_write_data,
   output logic               r1_ready,
   output logic [RDATA_W-1:0] r1_read_data,
   input  logic               sram_ready,
   input  logic [RDATA_W-1:0] sram_read_data,
   output logic               sram_rd_en,
   output logic               sram_wr_en,
   output logic [ADDR_W-1:0]  sram_address,
   output logic [WDATA_W-1:0] sram_write_data
);

   arb_state_e         state_q, state_d;
   logic               gnt_q, gnt_d;
   logic               last_gnt_q, last_gnt_d;
   logic               is_wr_q, is_wr_d;
   logic [RDATA_W-1:0] rdata0_q, rdata0_d;
   logic [RDATA_W-1:0] rdata1_q, rdata1_d;

   logic [1:0] req;
   logic       pick_valid;
   logic       pick;

   assign req = {r1_rd_en | r1_wr_en, r0_rd_en | r0_wr_en};

   arb_rr_pick u_pick (
      .req      (req),
      .last_gnt (last_gnt_q),
      .valid    (pick_valid),
      .pick     (pick)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      is_wr_d    = is_wr_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick;
               // A port asserting both enables is served as a write.
               is_wr_d = pick ? r1_wr_en : r0_wr_en;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            sram_rd_en = ~is_wr_q;
            sram_wr_en = is_wr_q;
            if (sram_ready) begin
               state_d    = ARB_DONE;
               last_gnt_d = gnt_q;
               if (!is_wr_q) begin
                  if (gnt_q) rdata1_d = sram_read_data;
                  else       rdata0_d = sram_read_data;
               end
            end
         end
         // One cycle so the requester can drop its enables before the
         // next arbitration in IDLE.
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         is_wr_q    <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         is_wr_q    <= is_wr_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   // Mux follows the gnt register directly; requesters keep address and
   // data stable while requesting, so nothing is latched here.
   assign sram_address    = gnt_q ? r1_address    : r0_address;
   assign sram_write_data = gnt_q ? r1_write_data : r0_write_data;

   assign r0_ready = ~req[0] | ((state_q == ARB_DONE) & ~gnt_q);
   assign r1_ready = ~req[1] | ((state_q == ARB_DONE) &  gnt_q);

   assign r0_read_data = rdata0_q;
   assign r1_read_data = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios followed by a
//   randomized phase, all checked every cycle against a transaction-level
//   reference model of the arbitration rules.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN (selects expected grant order).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r0_rd_en, r0_wr_en, r1_rd_en, r1_wr_en;
   logic [31:0] r0_address, r0_write_data, r1_address, r1_write_data;
   logic        r0_ready, r1_ready;
   logic [63:0] r0_read_data, r1_read_data;
   logic        sram_ready;
   logic [63:0] sram_read_data;
   logic        sram_rd_en, sram_wr_en;
   logic [31:0] sram_address, sram_write_data;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .r0_rd_en        (r0_rd_en),
      .r0_wr_en        (r0_wr_en),
      .r0_address      (r0_address),
      .r0_write_data   (r0_write_data),
      .r0_ready        (r0_ready),
      .r0_read_data    (r0_read_data),
      .r1_rd_en        (r1_rd_en),
      .r1_wr_en        (r1_wr_en),
      .r1_address      (r1_address),
      .r1_write_data   (r1_write_data),
      .r1_ready        (r1_ready),
      .r1_read_data    (r1_read_data),
      .sram_ready      (sram_ready),
      .sram_read_data  (sram_read_data),
      .sram_rd_en      (sram_rd_en),
      .sram_wr_en      (sram_wr_en),
      .sram_address    (sram_address),
      .sram_write_data (sram_write_data)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_owner: port currently holding the SRAM (-1 none)
   // m_done : port whose completion cycle is now (-1 none)
   int          m_owner, m_done, m_last;
   bit          m_wr;
   logic [63:0] m_rdata [2];

   function automatic int choose(bit q0, bit q1, int last);
      if (q0 && q1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         return 0;
`else
         return 1 - last;
`endif
      end
      if (q0) return 0;
      if (q1) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner   <= -1;
         m_done    <= -1;
         m_last    <= 1;
         m_wr      <= 1'b0;
         m_rdata[0] <= '0;
         m_rdata[1] <= '0;
      end else if (m_done >= 0) begin
         m_done <= -1;
      end else if (m_owner >= 0) begin
         if (sram_ready) begin
            if (!m_wr) m_rdata[m_owner] <= sram_read_data;
            m_last  <= m_owner;
            m_done  <= m_owner;
            m_owner <= -1;
         end
      end else begin
         int w;
         w = choose(r0_rd_en | r0_wr_en, r1_rd_en | r1_wr_en, m_last);
         m_owner <= w;
         m_wr    <= (w == 1) ? r1_wr_en : r0_wr_en;
      end
   end

   task automatic check_cycle();
      bit busy;
      busy = (m_owner >= 0);
      chk("sram_rd_en", sram_rd_en, busy && !m_wr);
      chk("sram_wr_en", sram_wr_en, busy && m_wr);
      if (busy) chk("sram_address", sram_address, (m_owner == 1) ? r1_address : r0_address);
      if (busy && m_wr) chk("sram_write_data", sram_write_data, (m_owner == 1) ? r1_write_data : r0_write_data);
      chk("r0_ready", r0_ready, !(r0_rd_en | r0_wr_en) || m_done == 0);
      chk("r1_ready", r1_ready, !(r1_rd_en | r1_wr_en) || m_done == 1);
      chk("r0_read_data", r0_read_data, m_rdata[0]);
      chk("r1_read_data", r1_read_data, m_rdata[1]);
   endtask

   // ---------------- stimulus environment ----------------
   bit   auto_mode  = 0;   // random requesters
   bit   rand_data  = 1;
   bit   stray_force = 0;
   int   fixed_lat  = 0;   // 0 = random 1..4
   int   lat        = 1;
   int   cnt        = 0;
   int   rem [2];
   int   log_q [$];
   int   rd_cyc, wr_cyc;
   int   pulses [2];

   function automatic int get_lat();
      return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
   endfunction

   task automatic set_req(input int p, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         r0_rd_en = rd; r0_wr_en = wr; r0_address = a; r0_write_data = d;
      end else begin
         r1_rd_en = rd; r1_wr_en = wr; r1_address = a; r1_write_data = d;
      end
   endtask

   // Drop enables but keep address/data as they were.
   task automatic drop(input int p);
      if (p == 0) begin r0_rd_en = 0; r0_wr_en = 0; end
      else        begin r1_rd_en = 0; r1_wr_en = 0; end
   endtask

   task automatic clear_stats();
      log_q.delete();
      rd_cyc = 0; wr_cyc = 0; pulses[0] = 0; pulses[1] = 0;
   endtask

   task automatic step();
      bit en [2];
      bit served [2];
      bit was_wr [2];
      @(negedge clk);
      check_cycle();
      en[0] = r0_rd_en | r0_wr_en;
      en[1] = r1_rd_en | r1_wr_en;
      was_wr[0] = r0_wr_en;
      was_wr[1] = r1_wr_en;
      served[0] = en[0] && r0_ready;
      served[1] = en[1] && r1_ready;
      if (sram_rd_en) rd_cyc++;
      if (sram_wr_en) wr_cyc++;
      for (int p = 0; p < 2; p++) if (served[p]) begin pulses[p]++; log_q.push_back(p); end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (served[p]) begin
            rem[p]--;
            if (rem[p] > 0) set_req(p, !was_wr[p], was_wr[p], $urandom, $urandom);
            else drop(p);
         end else if (auto_mode && !en[p] && ($urandom % 4 == 0)) begin
            bit w;
            w = $urandom % 2;
            set_req(p, !w, w, $urandom, $urandom);
            rem[p] = 1;
         end else if (auto_mode && en[p] && ($urandom % 40 == 0)) begin
            drop(p);   // requester gives up; a running transaction still completes
         end
      end
      if (rst && (sram_rd_en | sram_wr_en)) begin
         cnt++;
         if (cnt >= lat) begin sram_ready = 1; cnt = 0; lat = get_lat(); end
         else sram_ready = 0;
      end else begin
         cnt = 0;
         sram_ready = stray_force | (auto_mode && ($urandom % 8 == 0));
      end
      if (rand_data) sram_read_data = {$urandom, $urandom};
   endtask

   task automatic run_until(input int budget);
      int n = 0;
      while ((r0_rd_en | r0_wr_en | r1_rd_en | r1_wr_en) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("timeout", 1, 0);
      step();
      step();
   endtask

   task automatic do_reset(input bit keep_req);
      rst = 0;
      if (!keep_req) begin drop(0); drop(1); end
      sram_ready = 0;
      cnt = 0;
      repeat (2) step();
      chk("rst_sram_rd_en", sram_rd_en, 0);
      chk("rst_sram_wr_en", sram_wr_en, 0);
      chk("rst_r0_read_data", r0_read_data, 0);
      chk("rst_r1_read_data", r1_read_data, 0);
      if (!keep_req) begin
         chk("rst_r0_ready", r0_ready, 1);
         chk("rst_r1_ready", r1_ready, 1);
      end
      rst = 1;
   endtask

   initial begin
      logic [63:0] saved;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      sram_ready = 0;
      sram_read_data = 0;
      rem[0] = 0; rem[1] = 0;
      #1;
      do_reset(0);

      // 1: lone r0 read, sram_ready on the 4th BUSY cycle
      clear_stats();
      fixed_lat = 4; lat = 4; rand_data = 0;
      sram_read_data = 64'hDEAD_BEEF_0000_0001;
      set_req(0, 1, 0, 32'h100, 0); rem[0] = 1;
      run_until(30);
      chk("t1_rd_cycles", rd_cyc, 4);
      chk("t1_r0_pulses", pulses[0], 1);
      chk("t1_r0_read_data", r0_read_data, 64'hDEAD_BEEF_0000_0001);

      // 2: simultaneous reads after reset -> 0 then 1
      do_reset(0);
      clear_stats();
      fixed_lat = 0; lat = get_lat(); rand_data = 1;
      set_req(0, 1, 0, $urandom, 0); rem[0] = 1;
      set_req(1, 1, 0, $urandom, 0); rem[1] = 1;
      run_until(40);
      chk("t2_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("t2_first", log_q[0], 0);
         chk("t2_second", log_q[1], 1);
      end
      chk("t2_r1_pulses", pulses[1], 1);

      // 3: back-to-back simultaneous requests
      do_reset(0);
      clear_stats();
      begin
         int exp_q [$];
`ifdef MEM_ARB_FIXED_PRIO_EN
         rem[0] = 4; rem[1] = 1;
         exp_q = '{0, 0, 0, 0, 1};
`else
         rem[0] = 2; rem[1] = 2;
         exp_q = '{0, 1, 0, 1};
`endif
         set_req(0, 1, 0, $urandom, 0);
         set_req(1, 1, 0, $urandom, 0);
         run_until(80);
         chk("t3_count", log_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("t3_grant%0d", i), log_q[i], exp_q[i]);
      end

      // 4: r1 write, read data of port 1 untouched
      clear_stats();
      saved = r1_read_data;
      fixed_lat = 3; lat = 3;
      set_req(1, 0, 1, 32'h40, 32'h1234_5678); rem[1] = 1;
      run_until(30);
      chk("t4_wr_cycles", wr_cyc, 3);
      chk("t4_rd_cycles", rd_cyc, 0);
      chk("t4_r1_read_data", r1_read_data, saved);

      // 5: reset in the middle of BUSY
      clear_stats();
      fixed_lat = 10; lat = 10;
      set_req(0, 1, 0, 32'h200, 0); rem[0] = 1;
      repeat (3) step();
      chk("t5_busy_before", sram_rd_en, 1);
      rst = 0;
      #1;
      chk("t5_rd_en_in_reset", sram_rd_en, 0);
      chk("t5_r0_ready_in_reset", r0_ready, 0);
      cnt = 0; sram_ready = 0;
      repeat (2) step();
      rst = 1;
      clear_stats();
      fixed_lat = 2; lat = 2;
      run_until(30);
      chk("t5_regrant_count", log_q.size(), 1);
      if (log_q.size() == 1) chk("t5_regrant_port", log_q[0], 0);
      chk("t5_rd_cycles", rd_cyc, 2);

      // 6: stray sram_ready while idle
      clear_stats();
      saved = r0_read_data;
      stray_force = 1;
      repeat (3) step();
      stray_force = 0;
      sram_ready = 0;
      step();
      chk("t6_rd_cycles", rd_cyc, 0);
      chk("t6_r0_read_data", r0_read_data, saved);
      chk("t6_pulses", pulses[0] + pulses[1], 0);

      // random phase
      fixed_lat = 0; lat = get_lat();
      auto_mode = 1;
      repeat (1500) step();
      auto_mode = 0;
      run_until(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
